// File: rtl/program_loader.sv
// Boot loader: unpacks a header/payload word stream into instruction and data memory, then releases the CPU.
// Optional trailer checksum over all payload words is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        imem_we,
  output logic [31:0] imem_a,
  output logic [31:0] imem_wd,
  output logic        dmem_we,
  output logic [31:0] dmem_a,
  output logic [31:0] dmem_wd,
  output logic        cpu_run,
  output logic        busy,
  output logic        error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR, S_TRL} state_t;
`else
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

  localparam logic [16:0] IMEM_DEPTH = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_DEPTH = 17'(DMEM_WORDS);

  state_t      state, state_nx;
  logic        tgt, tgt_nx;
  logic [16:0] idx, idx_nx;
  logic [15:0] remaining, remaining_nx;
  logic        accept;
  logic        wr_fire;

  // Header decode; 17-bit sum so base + count can never wrap past the depth check.
  logic        hdr_tgt;
  logic [16:0] hdr_base;
  logic [16:0] hdr_cnt;
  logic [16:0] hdr_limit;
  logic [16:0] hdr_depth;

  assign hdr_tgt   = in_data[31];
  assign hdr_base  = {2'b00, in_data[30:16]};
  assign hdr_cnt   = {1'b0, in_data[15:0]};
  assign hdr_limit = hdr_base + hdr_cnt;
  assign hdr_depth = hdr_tgt ? DMEM_DEPTH : IMEM_DEPTH;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0] csum, csum_nx;
  assign in_ready = (state == S_HDR) || (state == S_DATA) || (state == S_TRL);
`else
  assign in_ready = (state == S_HDR) || (state == S_DATA);
`endif

  assign accept  = in_valid && in_ready;
  assign wr_fire = accept && (state == S_DATA);
  assign busy    = (state == S_DATA);
  assign cpu_run = (state == S_DONE);
  assign error   = (state == S_ERR);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_nx     = state;
    tgt_nx       = tgt;
    idx_nx       = idx;
    remaining_nx = remaining;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_nx      = csum;
`endif
    if (accept) begin
      case (state)
        S_HDR: begin
          if (hdr_cnt == 17'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_nx = S_TRL;
`else
            state_nx = S_DONE;
`endif
          end else if (hdr_limit > hdr_depth) begin
            state_nx = S_ERR;
          end else begin
            state_nx     = S_DATA;
            tgt_nx       = hdr_tgt;
            idx_nx       = hdr_base;
            remaining_nx = in_data[15:0];
          end
        end
        S_DATA: begin
          idx_nx       = idx + 17'd1;
          remaining_nx = remaining - 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_nx      = csum ^ in_data;
`endif
          if (remaining == 16'd1) state_nx = S_HDR;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_TRL: state_nx = (in_data == csum) ? S_DONE : S_ERR;
`endif
        default: state_nx = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HDR;
      tgt       <= 1'b0;
      idx       <= '0;
      remaining <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_nx;
      tgt       <= tgt_nx;
      idx       <= idx_nx;
      remaining <= remaining_nx;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum      <= csum_nx;
`endif
    end
  end

  // Registered write ports: a word accepted at edge k is presented during cycle k+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we <= 1'b0;
      imem_a  <= '0;
      imem_wd <= '0;
      dmem_we <= 1'b0;
      dmem_a  <= '0;
      dmem_wd <= '0;
    end else begin
      imem_we <= wr_fire && !tgt;
      dmem_we <= wr_fire && tgt;
      imem_a  <= {13'd0, idx, 2'b00};
      dmem_a  <= {13'd0, idx, 2'b00};
      imem_wd <= in_data;
      dmem_wd <= in_data;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a stimulus process predicts memory writes into a queue,
// a negedge monitor pops and compares every strobe the loader issues.
module tb_program_loader;
  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        imem_we, dmem_we, cpu_run, busy, error;
  logic [31:0] imem_a, imem_wd, dmem_a, dmem_wd;

  program_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .imem_we(imem_we), .imem_a(imem_a), .imem_wd(imem_wd),
    .dmem_we(dmem_we), .dmem_a(dmem_a), .dmem_wd(dmem_wd),
    .cpu_run(cpu_run), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] xsum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (imem_we === 1'b1 || dmem_we === 1'b1) begin
      if (imem_we === 1'b1 && dmem_we === 1'b1) check("both_strobes", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {imem_we, dmem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_target", {31'd0, dmem_we}, {31'd0, e.dm});
        check("wr_addr", e.dm ? dmem_a : imem_a, e.addr);
        check("wr_data", e.dm ? dmem_wd : imem_wd, e.data);
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (in_ready !== 1'b1) begin
      check("handshake_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int k, input bit chk_busy);
    in_valid = 1'b0;
    in_data  = $urandom;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      if (chk_busy) check("stall_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic pay(input bit dm, input int widx, input logic [31:0] d);
    wr_t e;
    e.dm = dm;
    e.addr = 32'(widx * 4);
    e.data = d;
    exp_q.push_back(e);
    xsum ^= d;
    send_word(d);
  endtask

  task automatic drain();
    idle(2, 1'b0);
    check("drain_queue", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    drain();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xsum = '0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outs", {imem_we, dmem_we, cpu_run, busy, error}, 32'd0);
  endtask

  // Header then n payload words with random stalls; reports whether the header overflowed.
  task automatic run_seg(input bit dm, input int base, input int n, input int max_stall, output bit ovf);
    int depth;
    depth = dm ? DMEM_WORDS : IMEM_WORDS;
    ovf = (base + n > depth);
    send_word({dm, 15'(base), 16'(n)});
    if (ovf) begin
      check("ovf_error", {31'd0, error}, 32'd1);
      check("ovf_ready", {31'd0, in_ready}, 32'd0);
      check("ovf_run", {31'd0, cpu_run}, 32'd0);
    end else begin
      check("seg_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
        if (max_stall > 0) idle($urandom_range(0, max_stall), 1'b1);
        pay(dm, base + i, $urandom);
      end
      check("seg_end_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic finish_image(input bit corrupt);
    send_word(32'h0000_0000);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check("trl_wait_run", {31'd0, cpu_run}, 32'd0);
    check("trl_ready", {31'd0, in_ready}, 32'd1);
    send_word(corrupt ? ~xsum : xsum);
    check("end_run", {31'd0, cpu_run}, corrupt ? 32'd0 : 32'd1);
    check("end_error", {31'd0, error}, corrupt ? 32'd1 : 32'd0);
`else
    check("end_run", {31'd0, cpu_run}, 32'd1);
    check("end_error", {31'd0, error}, 32'd0);
`endif
    check("end_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    bit ovf;
    do_reset();

    // Small instruction image at word 0.
    send_word(32'h0000_0003);
    pay(1'b0, 0, 32'h2008_0005);
    pay(1'b0, 1, 32'h2009_0007);
    pay(1'b0, 2, 32'h0109_5020);
    finish_image(1'b0);

    // Data segment at word 5.
    do_reset();
    send_word(32'h8005_0002);
    pay(1'b1, 5, 32'h0000_0011);
    pay(1'b1, 6, 32'h0000_0022);
    finish_image(1'b0);

    // Out of bounds by one word, then further input is ignored.
    do_reset();
    run_seg(1'b0, 63, 2, 0, ovf);
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("err_stays", {cpu_run, error, in_ready}, 32'b010);

    // Exactly-full segments at the top of both memories.
    do_reset();
    run_seg(1'b0, 62, 2, 0, ovf);
    run_seg(1'b1, 63, 1, 0, ovf);
    finish_image(1'b0);

    // Three-cycle stall between payload words.
    do_reset();
    send_word(32'h0010_0003);
    pay(1'b0, 16, $urandom);
    idle(3, 1'b1);
    pay(1'b0, 17, $urandom);
    idle(3, 1'b1);
    pay(1'b0, 18, $urandom);
    finish_image(1'b0);

    // Reset after the first of three payload words; the next word is a header.
    do_reset();
    send_word(32'h0010_0003);
    pay(1'b0, 16, $urandom);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xsum = '0;
    check("midrst_state", {cpu_run, busy, error, in_ready}, 32'b0001);
    run_seg(1'b1, 0, 1, 0, ovf);
    finish_image(1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    do_reset();
    send_word(32'h0000_0002);
    pay(1'b0, 0, 32'h0000_000F);
    pay(1'b0, 1, 32'h0000_00F0);
    send_word(32'h0000_0000);
    send_word(32'h0000_00FF);
    check("csum_good", {cpu_run, error}, 32'b10);
    do_reset();
    send_word(32'h0000_0002);
    pay(1'b0, 0, 32'h0000_000F);
    pay(1'b0, 1, 32'h0000_00F0);
    send_word(32'h0000_0000);
    send_word(32'h0000_00FE);
    check("csum_bad", {cpu_run, error}, 32'b01);
`endif

    // Randomised images with mixed targets, stalls and occasional overflow.
    for (int img = 0; img < 25; img++) begin
      int nseg;
      do_reset();
      nseg = $urandom_range(1, 3);
      ovf = 1'b0;
      for (int s = 0; s < nseg && !ovf; s++) begin
        bit dm;
        int n, depth, base;
        dm    = 1'($urandom_range(0, 1));
        n     = $urandom_range(1, 5);
        depth = dm ? DMEM_WORDS : IMEM_WORDS;
        if ($urandom_range(0, 7) == 0) base = depth - n + 1 + $urandom_range(0, 3);
        else base = $urandom_range(0, depth - n);
        run_seg(dm, base, n, 2, ovf);
      end
      if (!ovf) finish_image($urandom_range(0, 3) == 0);
    end

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time loader that fills the CPU's instruction memory and data memory from a 32-bit valid/ready word stream, then releases the single-cycle MIPS core.
- Holds cpu_run low while loading; raises it once a complete image has been written.
- Sits between an external host stream and the write ports of instruction_memory and data_memory.
- It is the writer-side counterpart of the post-run register/memory dump.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words; used for bounds checking.
DMEM_WORDS, 64, data memory depth in 32-bit words; used for bounds checking.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
in_valid  input  1  host has a word on in_data.
in_ready  output  1  loader accepts in_data this cycle.
in_data  input  32  header, payload or trailer word.
imem_we  output  1  instruction memory write strobe.
imem_a  output  32  instruction memory byte address (word index * 4).
imem_wd  output  32  instruction memory write data.
dmem_we  output  1  data memory write strobe.
dmem_a  output  32  data memory byte address (word index * 4).
dmem_wd  output  32  data memory write data.
cpu_run  output  1  high means the CPU may run; low holds the PC/CPU in reset.
busy  output  1  high in DATA state.
error  output  1  sticky error flag.

Behaviour:
Reset (rst_n low at a clock edge), applied even mid-load:
- state=HDR; all outputs 0 except in_ready=1.
- Word counter and base index cleared.
- Memories already written are not cleared.

Handshake:
- A word transfers on a rising edge where in_valid and in_ready are both 1.
- in_data is ignored otherwise.
- in_ready=1 in HDR and DATA (and TRL when enabled); 0 in DONE and ERR.

Header word fields:
- [31] target: 0=instruction memory, 1=data memory.
- [30:16] base word index.
- [15:0] count N.

States and transitions:
- HDR, header accepted, N=0 -> DONE. End marker; target and base are ignored.
- HDR, header accepted, N>0 and base+N <= depth of the selected target -> DATA. Latch target, base, remaining=N.
- HDR, header accepted, base+N > depth -> ERR.
- DATA, each accepted payload word -> write one word; remaining decrements; base increments.
- DATA, last payload word accepted (remaining was 1) -> HDR.
- DONE: terminal until reset. cpu_run=1 from the cycle after the end marker is accepted.
- ERR: terminal until reset. error=1, cpu_run=0.

Write timing:
- Writes are registered. For a payload word accepted at edge k, *_we/*_a/*_wd are valid during cycle k+1.
- The memory captures the write at edge k+1.
- The strobe is a one-cycle pulse per word; back-to-back words produce back-to-back strobes.
- Only the selected target's strobe asserts; the other *_we stays 0.
- *_a = (base + offset) * 4, zero-extended to 32 bits.
- *_a and *_wd are don't-care when the matching *_we is 0.

Other rules:
- A payload word is never interpreted as a header.
- Multiple segments may target the same memory. Overlapping writes: the later write wins.
- Bounds arithmetic uses 17 bits so base+N never wraps.
- Input stalls (in_valid low) in DATA hold all state; no strobe is issued.
- busy=1 exactly while state=DATA.

Optional Feature:
Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Enabled:
  - A running XOR of all accepted payload words is kept; cleared on reset.
  - The end marker moves HDR -> TRL instead of DONE.
  - The next accepted word is compared with the XOR: equal -> DONE; unequal -> ERR.
  - cpu_run rises the cycle after the trailer is accepted.
- Disabled: no TRL state, no trailer word, no XOR register; the end marker goes directly to DONE.

Test Plan:
1. Reset, then stream 0x00000003, 0x20080005, 0x20090007, 0x01095020, 0x00000000 -> imem_we pulses at byte addresses 0, 4, 8 with those words; cpu_run=1 one cycle after the end marker; error=0.
2. Data segment header 0x80050002 with payload 0x11, 0x22 -> dmem_we at addresses 20 and 24; imem_we never asserts.
3. Header 0x003F0002 with IMEM_WORDS=64 -> ERR: error=1, in_ready=0, no writes, cpu_run stays 0 after further input.
4. Hold in_valid low for 3 cycles between payload words -> no strobes during the stall; the remaining words are written to consecutive addresses; busy stays 1.
5. rst_n low for one edge after the 1st of 3 payload words -> state returns to HDR; the next word is decoded as a header; cpu_run=0.
6. With PROGRAM_LOADER_CHECKSUM_EN: payload 0x0F, 0xF0, end marker, trailer 0xFF -> cpu_run=1; repeat with trailer 0xFE -> error=1, cpu_run=0.
